// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

  // Access size/sign encodings carried on funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wait-state counter width; covers WAIT_CYCLES up to 15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Lane decode for one access: load extraction/extension, store byte enables, legality flags.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the selected request fields.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        misalign,
  output logic        bad_f3
);

  // Bring the addressed byte/half down to bit 0
  logic [31:0] shifted;
  assign shifted = word >> {lane, 3'b000};

  logic unused_hi;
  assign unused_hi = ^shifted[31:16];

  // Decode size: extended load data, lanes touched, alignment and encoding legality
  always_comb begin
    data     = '0;
    be       = '0;
    misalign = 1'b0;
    bad_f3   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be   = 4'b0001 << lane;
        data = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        misalign = lane[0];
        data     = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        be       = 4'b1111;
        misalign = |lane;
        data     = word;
      end
      default: bad_f3 = 1'b1;
    endcase
    // Unsigned variants only make sense for loads
    if (is_store && funct3[2]) bad_f3 = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a load/store, waits WAIT_CYCLES, accesses the RAM, pulses done.
// Latency: done WAIT_CYCLES+1 cycles after the request cycle; one access per WAIT_CYCLES+2 cycles.
// Backpressure: stall held from the request cycle until RESP; requests outside IDLE are ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        error,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             request;

  logic             l_rd, l_wr;
  logic [2:0]       l_f3;
  logic [31:0]      l_addr, l_wdata;

  assign request = MemRead | MemWrite;

  // With WAIT_CYCLES=0 the access happens on the latching edge itself, so
  // in IDLE the live inputs stand in for the not-yet-latched copies.
  logic        a_rd, a_wr;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata;
  assign a_rd    = (state == IDLE) ? MemRead  : l_rd;
  assign a_wr    = (state == IDLE) ? MemWrite : l_wr;
  assign a_f3    = (state == IDLE) ? funct3   : l_f3;
  assign a_addr  = (state == IDLE) ? addr     : l_addr;
  assign a_wdata = (state == IDLE) ? wdata    : l_wdata;

  logic unused_addr;
  assign unused_addr = ^a_addr[31:AW+2];

  logic [AW-1:0] idx;
  logic [31:0]   rword, ld_data, wlanes;
  logic [3:0]    be;
  logic          misalign, bad_f3, err, go_resp, we;
  logic [31:0]   mem [DEPTH_WORDS];

  assign idx   = a_addr[AW+1:2];
  assign rword = mem[idx];

  dmem_load_align u_align (
    .word     (rword),
    .lane     (a_addr[1:0]),
    .funct3   (a_f3),
    .is_store (a_wr),
    .data     (ld_data),
    .be       (be),
    .misalign (misalign),
    .bad_f3   (bad_f3)
  );

  assign err     = (a_rd & a_wr) | misalign | bad_f3;
  assign go_resp = (next_state == RESP);
  assign we      = go_resp & a_wr & ~err;

  // Replicate store data so every enabled lane sees the right byte/half
  assign wlanes = (a_f3[1:0] == 2'b00) ? {4{a_wdata[7:0]}}  :
                  (a_f3[1:0] == 2'b01) ? {2{a_wdata[15:0]}} : a_wdata;

  // State register and wait-state counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && request)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (request) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pipeline hold: from the request cycle through the last wait state
  always_comb begin
    stall = ((state == IDLE) && request) || (state == WAIT);
  end

  // Capture the request so later input changes cannot affect the access
  always_ff @(posedge clk) begin
    if (state == IDLE && request) begin
      l_rd    <= MemRead;
      l_wr    <= MemWrite;
      l_f3    <= funct3;
      l_addr  <= addr;
      l_wdata <= wdata;
    end
  end

  // RAM write on the edge entering RESP; a reset on that edge drops the store
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Registered response, valid only in the RESP cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      done  <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
    end else begin
      done  <= go_resp;
      error <= go_resp & err;
      rdata <= (go_resp && a_rd && !err) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
// Latency: checks done arrives exactly WAIT_CYCLES+1 cycles after each request.
// Backpressure: checks stall is high until RESP and low in RESP.
module tb_dmem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        experr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd_o [2];
  logic        dn [2];
  logic        er [2];
  logic        st [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .funct3(f3[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd_o[0]), .done(dn[0]), .error(er[0]), .stall(st[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .funct3(f3[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd_o[1]), .done(dn[1]), .error(er[1]), .stall(st[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] w,
                              input logic [31:0] e, input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f; v.addr = a; v.wdata = w; v.exp = e; v.experr = ee;
    return v;
  endfunction

  // Issue one request on instance sel and check latency, stall shape and response
  task automatic run_req(input int sel, input vec_t v, input string nm, input int exp_lat);
    int lat;
    bit st_ok;
    mr[sel] = v.rd; mw[sel] = v.wr; f3[sel] = v.f3; ad[sel] = v.addr; wd[sel] = v.wdata;
    #1;
    chk({nm, " stall_c0"}, st[sel], 1);
    lat = 0;
    st_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        mr[sel] = 1'b0; mw[sel] = 1'b0;
        ad[sel] = 32'hFFFF_FFFF; wd[sel] = 32'h0BAD_0BAD; f3[sel] = 3'b111;
      end
      #1;
      if (dn[sel]) begin
        lat = k;
        if (st[sel]) st_ok = 1'b0;
        break;
      end
      if (!st[sel]) st_ok = 1'b0;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " stall_shape"}, st_ok, 1);
    chk({nm, " rdata"}, rd_o[sel], v.exp);
    chk({nm, " error"}, er[sel], v.experr);
    @(posedge clk);
    #2;
    chk({nm, " done_drop"}, {er[sel], dn[sel]}, 0);
    chk({nm, " rdata_drop"}, rd_o[sel], 0);
  endtask

  vec_t tbl[$];

  initial begin
    int cnt;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; f3[i] = 3'b000; ad[i] = '0; wd[i] = '0;
    end

    // Reset held 3 cycles: all outputs quiet
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d done", i), dn[i], 0);
      chk($sformatf("rst%0d error", i), er[i], 0);
      chk($sformatf("rst%0d rdata", i), rd_o[i], 0);
      chk($sformatf("rst%0d stall", i), st[i], 0);
    end
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      if (dn[0] || dn[1] || st[0] || st[1]) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    // Vector table: {rd, wr, funct3, addr, wdata, expected rdata, expected error}
    tbl.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0));        // sw
    tbl.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0));        // lw
    tbl.push_back(mk(1, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0));        // lb
    tbl.push_back(mk(1, 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0));        // lbu
    tbl.push_back(mk(1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0));        // lh
    tbl.push_back(mk(0, 1, 3'b000, 32'h11, 32'h00000055, 32'h0, 0));        // sb
    tbl.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0));        // lw
    tbl.push_back(mk(1, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0));        // lhu
    tbl.push_back(mk(1, 0, 3'b001, 32'h10, 32'h0, 32'h000055EF, 0));        // lh low
    tbl.push_back(mk(1, 0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0));        // lb lane0
    tbl.push_back(mk(1, 0, 3'b000, 32'h11, 32'h0, 32'h00000055, 0));        // lb lane1
    tbl.push_back(mk(0, 1, 3'b010, 32'h04, 32'h11223344, 32'h0, 0));        // sw
    tbl.push_back(mk(1, 0, 3'b001, 32'h01, 32'h0, 32'h0, 1));               // lh misaligned
    tbl.push_back(mk(0, 1, 3'b010, 32'h06, 32'hCAFEF00D, 32'h0, 1));        // sw misaligned
    tbl.push_back(mk(1, 0, 3'b010, 32'h04, 32'h0, 32'h11223344, 0));        // lw unchanged
    tbl.push_back(mk(1, 1, 3'b010, 32'h04, 32'h99999999, 32'h0, 1));        // rd+wr
    tbl.push_back(mk(1, 0, 3'b011, 32'h04, 32'h0, 32'h0, 1));               // illegal f3
    tbl.push_back(mk(0, 1, 3'b100, 32'h04, 32'hFFFFFFFF, 32'h0, 1));        // store f3=100
    tbl.push_back(mk(0, 1, 3'b001, 32'h06, 32'h0000ABCD, 32'h0, 0));        // sh upper
    tbl.push_back(mk(1, 0, 3'b010, 32'h04, 32'h0, 32'hABCD3344, 0));        // lw after sh
    tbl.push_back(mk(0, 1, 3'b010, 32'h20, 32'h01020304, 32'h0, 0));        // sw 0x20

    @(posedge clk);
    #2;
    foreach (tbl[i]) run_req(0, tbl[i], $sformatf("v%0d", i), 3);

    // Reset in cycle 1 of a store: no done, store dropped
    mr[0] = 1'b0; mw[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h20; wd[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    mw[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid stall", st[0], 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (dn[0]) cnt++;
      @(posedge clk);
      #2;
    end
    chk("rst_mid no_done", cnt, 0);
    run_req(0, mk(1, 0, 3'b010, 32'h20, 32'h0, 32'h01020304, 0), "rst_mid lw", 3);

    // WAIT_CYCLES=0 instance: done on cycle 1, back-to-back
    run_req(1, mk(0, 1, 3'b010, 32'h08, 32'hA5A5C3C3, 32'h0, 0), "w0 sw", 1);
    run_req(1, mk(1, 0, 3'b010, 32'h08, 32'h0, 32'hA5A5C3C3, 0), "w0 lw", 1);
    run_req(1, mk(1, 0, 3'b000, 32'h0B, 32'h0, 32'hFFFFFFA5, 0), "w0 lb", 1);
    run_req(1, mk(1, 1, 3'b010, 32'h08, 32'h0, 32'h0, 1), "w0 rdwr", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the main control unit's MemRead/MemWrite interface. Accepts load/store requests from the EX/MEM stage, inserts a fixed number of wait states, performs byte/half/word access on an internal word-organised RAM, and returns load data with a one-cycle done pulse. While a request is in flight, `stall` holds the pipeline.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states before access; 0 to 15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemRead`  in  1  load request from control path.
- `MemWrite`  in  1  store request from control path.
- `funct3`  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
- `addr`  in  32  byte address (ALU result); word index = addr[log2(DEPTH_WORDS)+1:2], upper bits ignored.
- `wdata`  in  32  store data; low byte/half used for sb/sh.
- `rdata`  out  32  load result, sign/zero-extended; valid only while `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `done`: request rejected, no memory side effect.
- `stall`  out  1  pipeline hold.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset -> IDLE.
- IDLE: request = MemRead | MemWrite. On request, latch MemRead, MemWrite, funct3, addr, wdata; go to WAIT with counter = WAIT_CYCLES−1, or to RESP directly if WAIT_CYCLES = 0.
- WAIT: counter decrements each cycle; at 0, go to RESP.
- RESP: one cycle; `done`=1; next state IDLE unconditionally. A request still present in the next IDLE cycle is treated as a new request.
- Access is performed on the edge entering RESP, using latched values only; inputs changing during WAIT are ignored.
- Store: byte-enable write of the addressed lanes (sb one lane by addr[1:0], sh lanes by addr[1], sw all four).
- Load: word read, lane extraction, sign extension for lb/lh; zero extension for lbu/lhu.
- Error conditions (checked on latched values): MemRead & MemWrite both set; half access with addr[0]=1; word access with addr[1:0]≠0; illegal funct3 (011, 110, 111; or 100/101 on a store). On error: no write, `rdata`=0, `error`=1 with `done`.
- RAM contents are not cleared by reset; they are undefined at power-up.

## Timing
- Reset values: `rdata`=0, `done`=0, `error`=0, `stall`=0, state IDLE, counter 0.
- `stall` = (state==IDLE & request) | (state==WAIT); combinational; 0 in RESP so the pipeline advances on the `done` edge.
- Latency: `done` asserted WAIT_CYCLES+1 cycles after the request cycle (cycle 0).
- `rdata`, `done`, `error` registered; all drop to 0 the cycle after RESP.
- Reset during WAIT or RESP: returns to IDLE next edge, no `done`, pending store discarded (write occurs only entering RESP).
- Back-to-back: minimum one IDLE cycle between requests; throughput one access per WAIT_CYCLES+2 cycles.

## Structure
- Shared package `dmem_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE, WAIT, RESP), counter width of 4.
- One sub-module: `dmem_load_align` (combinational: word, addr[1:0], funct3 -> extended rdata, plus misalignment flag), reused for store lane enables.

## Test plan
- Reset, WAIT_CYCLES=2: assert reset 3 cycles -> all outputs 0, stall 0; no done for 10 idle cycles.
- sw 0xDEADBEEF to 0x10, then lw 0x10 -> each done at cycle 3, stall high cycles 0–2, lw rdata=0xDEADBEEF, error 0.
- After the above: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; sb 0x55 to 0x11, then lw 0x10 -> 0xDEAD55EF.
- lh at 0x01 and sw at 0x06 -> done with error=1, rdata=0; lw 0x04 afterwards returns its prior contents.
- MemRead=MemWrite=1 -> error done, no write; WAIT_CYCLES=0 build: lw completes with done on cycle 1.
- Reset asserted in cycle 1 of an sw to 0x20 -> no done; following lw 0x20 returns the old value.
